// File: rtl/encoder_frontend.sv
// encoder_frontend: quadrature encoder input conditioning for one channel.
// Raw A/B pads are synchronised (2-FF) and debounced per channel. Full
// quadrature cycles are decoded into step_up/step_down pulses that move a
// WIDTH-bit level value.
// Optional build macro ENC_SATURATE_EN: when defined, the value clamps at
// its limits instead of wrapping. The step pulses still fire at the limit.
// Interface: no handshake. value is a level; step_up, step_down and err are
// single-cycle pulses, and at most one of them is high in any cycle.
module encoder_frontend #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             step_up,
  output logic             step_down,
  output logic             err
);

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [16:0] START_LEN = 17'(DEBOUNCE_CYCLES + 3);

  logic [1:0]        sync_a;
  logic [1:0]        sync_b;
  logic [1:0]        synced;     // {a, b} after synchronisation
  logic [15:0]       db_cnt [2];
  logic [1:0]        db_q;       // debounced {a, b}
  logic [1:0]        prev_q;     // debounced {a, b} from the previous cycle
  logic [16:0]       st_cnt;
  logic              startup;
  logic signed [2:0] acc_q;
  logic signed [2:0] acc_d;
  logic [WIDTH-1:0]  value_q;
  logic [WIDTH-1:0]  value_d;
  logic [WIDTH-1:0]  value_inc;
  logic [WIDTH-1:0]  value_dec;
  logic              up_d;
  logic              dn_d;
  logic              err_d;
  logic [1:0]        diff;

  // Gray position along the clockwise sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  assign synced  = {sync_a[1], sync_b[1]};
  assign startup = (st_cnt != START_LEN);
  assign diff    = gray_pos(db_q) - gray_pos(prev_q);

`ifdef ENC_SATURATE_EN
  assign value_inc = (value_q == {WIDTH{1'b1}}) ? value_q : value_q + WIDTH'(1);
  assign value_dec = (value_q == '0) ? value_q : value_q - WIDTH'(1);
`else
  assign value_inc = value_q + WIDTH'(1);
  assign value_dec = value_q - WIDTH'(1);
`endif

  // Two-flop synchronisers for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[0], enc_a};
      sync_b <= {sync_b[0], enc_b};
    end
  end

  // Per-channel debounce: the input must differ for DEBOUNCE_CYCLES
  // consecutive clocks before the debounced level follows it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == db_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEB_LAST) begin
          db_q[i]   <= synced[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Startup window: let the decoder learn the settled pad state quietly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_cnt <= '0;
    end else if (startup) begin
      st_cnt <= st_cnt + 17'd1;
    end
  end

  // Decode the quarter step and update the accumulator, value and pulses.
  always_comb begin
    acc_d   = acc_q;
    value_d = value_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    if (!startup) begin
      if (diff == 2'd2) begin
        err_d = 1'b1;
        acc_d = '0;
      end else if (diff == 2'd1) begin
        if (acc_q == 3'sd3) begin
          up_d    = 1'b1;
          acc_d   = '0;
          value_d = value_inc;
        end else begin
          acc_d = acc_q + 3'sd1;
        end
      end else if (diff == 2'd3) begin
        if (acc_q == -3'sd3) begin
          dn_d    = 1'b1;
          acc_d   = '0;
          value_d = value_dec;
        end else begin
          acc_d = acc_q - 3'sd1;
        end
      end
    end
    // Clear overrides any step completing in the same cycle.
    if (clear) begin
      acc_d   = '0;
      value_d = '0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      acc_q     <= '0;
      value_q   <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_q    <= db_q;
      acc_q     <= acc_d;
      value_q   <= value_d;
      step_up   <= up_d;
      step_down <= dn_d;
      err       <= err_d;
    end
  end

  assign value = value_q;

endmodule

// File: tb/tb_encoder_frontend.sv
// tb_encoder_frontend: directed self-checking bench for encoder_frontend
// with the default parameters (WIDTH=8, DEBOUNCE_CYCLES=16).
// Expectations follow ENC_SATURATE_EN when the macro is defined.
module tb_encoder_frontend;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] value;
  logic       step_up;
  logic       step_down;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int err_cnt = 0;
  int multi_cnt = 0;
  int wide_cnt = 0;
  int exp_val = 0;
  int up_base;
  int dn_base;
  int err_base;
  logic last_up = 1'b0;
  logic last_dn = 1'b0;
  logic last_err = 1'b0;

  encoder_frontend #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .clear     (clear),
    .value     (value),
    .step_up   (step_up),
    .step_down (step_down),
    .err       (err)
  );

  // Clock
  always #5 clk = ~clk;

  // Pulse monitor on the falling edge: counts pulses and flags overlap or
  // pulses wider than one clock.
  always @(negedge clk) begin
    if (step_up) up_cnt++;
    if (step_down) dn_cnt++;
    if (err) err_cnt++;
    if ((32'(step_up) + 32'(step_down) + 32'(err)) > 1) multi_cnt++;
    if ((step_up && last_up) || (step_down && last_dn) || (err && last_err)) wide_cnt++;
    last_up  = step_up;
    last_dn  = step_down;
    last_err = err;
  end

  function automatic int inc_v(input int v);
`ifdef ENC_SATURATE_EN
    return (v == 255) ? 255 : v + 1;
`else
    return (v + 1) % 256;
`endif
  endfunction

  function automatic int dec_v(input int v);
`ifdef ENC_SATURATE_EN
    return (v == 0) ? 0 : v - 1;
`else
    return (v + 255) % 256;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive {a,b} at a falling edge, then hold for gap clocks.
  task automatic drive(input logic [1:0] ab, input int gap);
    @(negedge clk);
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic cw_cycle(input int gap);
    drive(2'b01, gap);
    drive(2'b11, gap);
    drive(2'b10, gap);
    drive(2'b00, gap);
  endtask

  initial begin
    // Reset
    #2 reset_n = 1'b0;
    #1;
    check("reset_value", 32'(value), 0);
    check("reset_step_up", 32'(step_up), 0);
    check("reset_step_down", 32'(step_down), 0);
    check("reset_err", 32'(err), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);

    // One clockwise cycle with exact latency on the final edge
    drive(2'b01, 40);
    drive(2'b11, 40);
    drive(2'b10, 40);
    check("cw_no_early_step", up_cnt, 0);
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    check("cw_edge17_step_up", 32'(step_up), 0);
    check("cw_edge17_value", 32'(value), 0);
    @(posedge clk);
    #1;
    check("cw_edge18_step_up", 32'(step_up), 1);
    check("cw_edge18_value", 32'(value), 1);
    @(posedge clk);
    #1;
    check("cw_edge19_step_up", 32'(step_up), 0);
    exp_val = 1;

    // 256 clockwise cycles from 0
    pulse_clear();
    exp_val = 0;
    check("clear_value", 32'(value), exp_val);
    up_base = up_cnt;
    for (int i = 0; i < 255; i++) begin
      cw_cycle(20);
      exp_val = inc_v(exp_val);
    end
    check("wrap_255_value", 32'(value), 255);
    cw_cycle(20);
    exp_val = inc_v(exp_val);
`ifdef ENC_SATURATE_EN
    check("wrap_256_value", 32'(value), 255);
`else
    check("wrap_256_value", 32'(value), 0);
`endif
    check("wrap_256_pulses", up_cnt - up_base, 256);

    // Counter-clockwise cycle at value 0
    pulse_clear();
    exp_val = 0;
    dn_base = dn_cnt;
    drive(2'b10, 20);
    drive(2'b11, 20);
    drive(2'b01, 20);
    drive(2'b00, 20);
    exp_val = dec_v(exp_val);
`ifdef ENC_SATURATE_EN
    check("ccw_value", 32'(value), 0);
`else
    check("ccw_value", 32'(value), 255);
`endif
    check("ccw_pulses", dn_cnt - dn_base, 1);

    // 10-clock glitch on enc_a
    up_base  = up_cnt;
    dn_base  = dn_cnt;
    err_base = err_cnt;
    @(negedge clk);
    enc_a = 1'b1;
    repeat (10) @(negedge clk);
    enc_a = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch_value", 32'(value), exp_val);
    check("glitch_activity", (up_cnt - up_base) + (dn_cnt - dn_base) + (err_cnt - err_base), 0);

    // Illegal transition clears a partial accumulation
    err_base = err_cnt;
    up_base  = up_cnt;
    drive(2'b01, 20);
    drive(2'b10, 20);
    check("illegal_err", err_cnt - err_base, 1);
    check("illegal_value", 32'(value), exp_val);
    drive(2'b00, 20);
    drive(2'b01, 20);
    drive(2'b11, 20);
    check("after_err_3q_value", 32'(value), exp_val);
    drive(2'b10, 20);
    exp_val = inc_v(exp_val);
    check("after_err_4q_value", 32'(value), exp_val);
    check("after_err_pulses", up_cnt - up_base, 1);
    drive(2'b00, 20);
    drive(2'b11, 20);
    drive(2'b00, 20);
    check("both_switch_err", err_cnt - err_base, 3);
    check("both_switch_value", 32'(value), exp_val);

    // Half cycle then reverse, then clear racing a completing step
    cw_cycle(20);
    exp_val = inc_v(exp_val);
    check("pre_half_value", 32'(value), exp_val);
    up_base = up_cnt;
    drive(2'b01, 20);
    drive(2'b11, 20);
    drive(2'b01, 20);
    drive(2'b00, 20);
    check("half_reverse_value", 32'(value), exp_val);
    check("half_reverse_pulses", (up_cnt - up_base) + (dn_cnt - dn_base), 0);
    drive(2'b01, 20);
    drive(2'b11, 20);
    drive(2'b10, 20);
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    @(posedge clk);
    repeat (17) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear_race_step_up", 32'(step_up), 0);
    check("clear_race_value", 32'(value), 0);
    @(negedge clk);
    clear = 1'b0;
    repeat (5) @(negedge clk);
    check("clear_race_pulses", up_cnt - up_base, 0);
    exp_val = 0;
    cw_cycle(20);
    exp_val = inc_v(exp_val);
    check("after_clear_cycle_value", 32'(value), exp_val);

    // Asynchronous reset mid-cycle, then startup window behaviour
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_value", 32'(value), 0);
    check("async_reset_pulses", 32'(step_up) + 32'(step_down) + 32'(err), 0);
    exp_val = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    up_base  = up_cnt;
    err_base = err_cnt;
    repeat (40) @(negedge clk);
    check("startup_quiet", (up_cnt - up_base) + (err_cnt - err_base), 0);
    drive(2'b11, 20);
    drive(2'b10, 20);
    drive(2'b00, 20);
    check("startup_3q_value", 32'(value), exp_val);
    drive(2'b01, 20);
    exp_val = inc_v(exp_val);
    check("startup_4q_value", 32'(value), exp_val);
    check("startup_4q_pulses", up_cnt - up_base, 1);

    // Pulse shape over the whole run
    check("exclusive_pulses", multi_cnt, 0);
    check("single_cycle_pulses", wide_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
